md_sched: RTL and testbench

Multiply/divide scheduler for the five-stage pipeline. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the E stage, runs a fixed-latency multi-cycle operation, owns the HI/LO registers, and raises a stall toward the D→E pipeline register whenever the instruction in D needs the unit while it is occupied. Downstream, the stall zeroes the E-stage register fields except PC and BD, so a bubble enters E.

---
 rtl/md_sched.sv | 168 ++++++++++++++++
 tb/tb_md_sched.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/md_sched.sv
// Multiply/divide scheduler: fixed-latency MULT/DIV sequencing, HI/LO ownership,
// and the combinational stall request toward the D->E pipeline register.
module md_sched #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        cancel,
  input  logic        md_use_D,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        stall_md
);

  localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_hi_n;
  logic [31:0]      r_lo_n;
  logic             r_divz;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;

  state_t           w_state_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic [31:0]      w_hi_n_next;
  logic [31:0]      w_lo_n_next;
  logic             w_divz_next;
  logic [31:0]      w_hi_next;
  logic [31:0]      w_lo_next;

  logic             w_accept;
  logic             w_md_write_op;
  logic signed [63:0] w_prod_s;
  logic [63:0]      w_prod_u;

  logic             w_div_signed;
  logic             w_a_neg;
  logic             w_b_neg;
  logic             w_b_zero;
  logic [31:0]      w_mag_a;
  logic [31:0]      w_mag_b;
  logic [31:0]      w_div_den;
  logic [31:0]      w_quo_mag;
  logic [31:0]      w_rem_mag;
  logic [31:0]      w_quo;
  logic [31:0]      w_rem;

  assign w_accept      = start & ~cancel & (r_state == S_IDLE);
  assign w_md_write_op = (op == OP_MULT) | (op == OP_MULTU) | (op == OP_DIV) | (op == OP_DIVU);

  assign w_prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign w_prod_u = {32'd0, A} * {32'd0, B};

  // Signed division runs on magnitudes and re-applies signs afterwards; this
  // yields 0x80000000 / -1 = 0x80000000 rem 0 without a special case.
  assign w_div_signed = (op == OP_DIV);
  assign w_a_neg      = w_div_signed & A[31];
  assign w_b_neg      = w_div_signed & B[31];
  assign w_b_zero     = (B == 32'd0);
  assign w_mag_a      = w_a_neg ? (~A + 32'd1) : A;
  assign w_mag_b      = w_b_neg ? (~B + 32'd1) : B;
  assign w_div_den    = w_b_zero ? 32'd1 : w_mag_b;
  assign w_quo_mag    = w_mag_a / w_div_den;
  assign w_rem_mag    = w_mag_a % w_div_den;
  assign w_quo        = (w_a_neg ^ w_b_neg) ? (~w_quo_mag + 32'd1) : w_quo_mag;
  assign w_rem        = w_a_neg ? (~w_rem_mag + 32'd1) : w_rem_mag;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_hi_n_next  = r_hi_n;
    w_lo_n_next  = r_lo_n;
    w_divz_next  = r_divz;
    w_hi_next    = r_hi;
    w_lo_next    = r_lo;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (op)
            OP_MULT: begin
              {w_hi_n_next, w_lo_n_next} = w_prod_s;
              w_state_next = S_MUL;
              w_cnt_next   = CNT_W'(MULT_CYC);
            end
            OP_MULTU: begin
              {w_hi_n_next, w_lo_n_next} = w_prod_u;
              w_state_next = S_MUL;
              w_cnt_next   = CNT_W'(MULT_CYC);
            end
            OP_DIV, OP_DIVU: begin
              w_lo_n_next  = w_quo;
              w_hi_n_next  = w_rem;
              w_divz_next  = w_b_zero;
              w_state_next = S_DIV;
              w_cnt_next   = CNT_W'(DIV_CYC);
            end
            OP_MTHI: w_hi_next = A;
            OP_MTLO: w_lo_next = A;
            default: ;
          endcase
        end
      end
      S_MUL, S_DIV: begin
        w_cnt_next = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_state_next = S_IDLE;
          // Division by zero keeps the architectural HI/LO untouched.
          if (!(r_state == S_DIV && r_divz)) begin
            w_hi_next = r_hi_n;
            w_lo_next = r_lo_n;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_hi_n  <= 32'd0;
      r_lo_n  <= 32'd0;
      r_divz  <= 1'b0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_hi_n  <= w_hi_n_next;
      r_lo_n  <= w_lo_n_next;
      r_divz  <= w_divz_next;
      r_hi    <= w_hi_next;
      r_lo    <= w_lo_next;
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign HI       = r_hi;
  assign LO       = r_lo;
  assign stall_md = md_use_D & (busy | (start & ~cancel & w_md_write_op));

endmodule

// File: tb/tb_md_sched.sv
// Scoreboard bench for md_sched: expected HI/LO queued at issue, compared when
// busy drops; busy length and stall_md cycles are counted per operation.
module tb_md_sched;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        cancel;
  logic        md_use_D;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        stall_md;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  int          n_total;
  int          n_bad;

  md_sched #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .cancel(cancel), .md_use_D(md_use_D), .busy(busy), .HI(HI), .LO(LO),
    .stall_md(stall_md)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference behaviour written independently of the RTL datapath.
  task automatic model_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint          ps;
    longint unsigned pu;
    int              sa;
    int              sbv;
    sa  = int'(a);
    sbv = int'(b);
    case (o)
      3'd1: begin ps = longint'(sa) * longint'(sbv); m_hi = ps[63:32]; m_lo = ps[31:0]; end
      3'd2: begin pu = {32'd0, a} * {32'd0, b}; m_hi = pu[63:32]; m_lo = pu[31:0]; end
      3'd3: if (b != 32'd0) begin
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          m_lo = 32'h8000_0000; m_hi = 32'd0;
        end else begin
          m_lo = 32'(sa / sbv); m_hi = 32'(sa % sbv);
        end
      end
      3'd4: if (b != 32'd0) begin m_lo = a / b; m_hi = a % b; end
      3'd5: m_hi = a;
      3'd6: m_lo = a;
      default: ;
    endcase
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic use_d, input logic cxl_mid, input string tag);
    int   n;
    int   ns;
    int   exp_n;
    exp_t e;
    model_op(o, a, b);
    e.tag = tag; e.hi = m_hi; e.lo = m_lo;
    sb.push_back(e);
    exp_n = (o == 3'd1 || o == 3'd2) ? 5 : ((o == 3'd3 || o == 3'd4) ? 10 : 0);
    start = 1'b1; op = o; A = a; B = b; md_use_D = use_d;
    #1;
    check({tag, ":stall_start"}, 32'(stall_md), 32'(use_d && exp_n != 0));
    step();
    start = 1'b0; op = 3'd0; A = $urandom; B = $urandom;
    n = 0; ns = 0;
    while (busy && n < 64) begin
      n++;
      if (stall_md) ns++;
      if (cxl_mid && n == 2) cancel = 1'b1;
      step();
    end
    cancel = 1'b0;
    check({tag, ":busy_cycles"}, 32'(n), 32'(exp_n));
    if (use_d) begin
      check({tag, ":stall_busy_cycles"}, 32'(ns), 32'(exp_n));
      check({tag, ":stall_after"}, 32'(stall_md), 32'd0);
    end
    e = sb.pop_front();
    check({e.tag, ":HI"}, HI, e.hi);
    check({e.tag, ":LO"}, LO, e.lo);
    $display("op=%0d A=%08h B=%08h -> HI=%08h LO=%08h busy_cycles=%0d", o, a, b, HI, LO, n);
    md_use_D = 1'b0;
  endtask

  initial begin
    n_total = 0; n_bad = 0;
    m_hi = 32'd0; m_lo = 32'd0;
    reset = 1'b1; start = 1'b0; op = 3'd0; A = 32'd0; B = 32'd0;
    cancel = 1'b0; md_use_D = 1'b0;
    step(); step();
    check("reset:busy", 32'(busy), 32'd0);
    check("reset:HI", HI, 32'd0);
    check("reset:LO", LO, 32'd0);
    check("reset:stall", 32'(stall_md), 32'd0);
    reset = 1'b0;
    step();

    run_op(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b1, 1'b0, "mult");
    check("mult:HI_const", HI, 32'hFFFF_FFFF);
    check("mult:LO_const", LO, 32'hFFFF_FFFA);
    run_op(3'd2, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0, "multu");
    check("multu:HI_const", HI, 32'h0000_0002);
    check("multu:LO_const", LO, 32'hFFFF_FFFA);
    check("multu:no_stall", 32'(stall_md), 32'd0);
    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, "div");
    check("div:LO_const", LO, 32'hFFFF_FFFD);
    check("div:HI_const", HI, 32'hFFFF_FFFF);
    run_op(3'd4, 32'd7, 32'd2, 1'b0, 1'b0, "divu");
    check("divu:LO_const", LO, 32'd3);
    check("divu:HI_const", HI, 32'd1);

    run_op(3'd5, 32'h0000_1234, 32'd0, 1'b0, 1'b0, "mthi");
    run_op(3'd6, 32'h0000_5678, 32'd0, 1'b0, 1'b0, "mtlo");
    run_op(3'd3, 32'd99, 32'd0, 1'b1, 1'b0, "div_by_zero");
    check("divz:HI_const", HI, 32'h0000_1234);
    check("divz:LO_const", LO, 32'h0000_5678);
    run_op(3'd4, 32'd99, 32'd0, 1'b0, 1'b0, "divu_by_zero");
    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, "div_overflow");
    check("divovf:LO_const", LO, 32'h8000_0000);
    check("divovf:HI_const", HI, 32'd0);

    // start together with cancel: nothing happens
    start = 1'b1; cancel = 1'b1; op = 3'd1; A = 32'd5; B = 32'd6; md_use_D = 1'b1;
    #1;
    check("cancel:stall", 32'(stall_md), 32'd0);
    step();
    start = 1'b0; cancel = 1'b0; md_use_D = 1'b0;
    check("cancel:busy", 32'(busy), 32'd0);
    check("cancel:HI", HI, m_hi);
    check("cancel:LO", LO, m_lo);

    // undefined op codes are ignored
    start = 1'b1; op = 3'd7; A = 32'hDEAD_BEEF;
    step();
    start = 1'b0; op = 3'd0;
    check("op7:busy", 32'(busy), 32'd0);
    check("op7:HI", HI, m_hi);
    check("op7:LO", LO, m_lo);

    run_op(3'd3, 32'd1000, 32'hFFFF_FFF9, 1'b1, 1'b1, "div_cancel_mid");

    for (int i = 0; i < 8; i++) begin
      logic [2:0]  ro;
      logic [31:0] ra;
      logic [31:0] rb;
      ro = 3'($urandom_range(1, 4));
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : ((ro >= 3'd3) ? (32'($urandom) >> $urandom_range(0, 28)) : $urandom);
      run_op(ro, ra, rb, 1'($urandom_range(0, 1)), 1'b0, $sformatf("rand%0d", i));
    end

    // reset during busy cycle 3 of a division discards the result
    start = 1'b1; op = 3'd3; A = 32'd1000; B = 32'd7;
    step();
    start = 1'b0; op = 3'd0;
    step(); step();
    check("rstmid:busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    check("rstmid:busy", 32'(busy), 32'd0);
    check("rstmid:HI", HI, 32'd0);
    check("rstmid:LO", LO, 32'd0);
    run_op(3'd6, 32'h0000_ABCD, 32'd0, 1'b0, 1'b0, "mtlo_after_reset");

    // accept and reset on the same edge: reset wins
    start = 1'b1; op = 3'd1; A = 32'd3; B = 32'd4; reset = 1'b1;
    step();
    start = 1'b0; reset = 1'b0; op = 3'd0;
    check("rst_vs_accept:busy", 32'(busy), 32'd0);
    check("rst_vs_accept:LO", LO, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
